// File: rtl/anim_frame_stepper.sv
// Frame sequencer for the 7-segment animation pipeline: synchronises the raw
// select/pause/step pins, commits the animation id and steps a frame index
// 0..limit-1 at a programmable rate with wrap-around, pause and single-step.
// Latency: anim_sel->anim 3 edges, step_btn->frame 4 edges, pause->freeze 3 edges.
// Flow control: none; outputs are free-running, ena=0 freezes all state.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          global enable (low holds every flop, pulse outputs forced 0)
//   anim_sel     raw animation select (async pins)
//   speed        rate select, frame period = 2^(PRESCALE_W-speed) cycles
//   pause        raw pause level (async pin)
//   step_btn     raw single-step button (async pin)
//   limit        frame count for `anim`, combinational from the limit lookup
//   anim         committed animation id
//   frame        current frame index
//   frame_tick   one-cycle pulse in the first cycle a new frame is visible
//   wrap         one-cycle pulse with frame_tick when frame returns to 0
module anim_frame_stepper #(
    parameter int PRESCALE_W = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] anim_sel,
    input  logic [1:0] speed,
    input  logic       pause,
    input  logic       step_btn,
    input  logic [4:0] limit,
    output logic [2:0] anim,
    output logic [4:0] frame,
    output logic       frame_tick,
    output logic       wrap
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_LOAD   = 2'd2
    } state_t;

    // Synchronisers and step edge detector
    logic [2:0] asel_s1_q, asel_s1_d, asel_s2_q, asel_s2_d;
    logic       pause_s1_q, pause_s1_d, pause_s2_q, pause_s2_d;
    logic       step_s1_q, step_s1_d, step_s2_q, step_s2_d;
    logic       step_s3_q, step_s3_d, step_evt_q, step_evt_d;

    // Sequencer state
    state_t                  state_q, state_d;
    logic [2:0]              anim_q, anim_d;
    logic [4:0]              frame_q, frame_d;
    logic [PRESCALE_W-1:0]   pre_q, pre_d;
    logic                    tick_q, tick_d;
    logic                    wrap_q, wrap_d;

    logic [PRESCALE_W-1:0]   tc;
    logic [4:0]              last_frame;
    logic                    load_req;
    logic                    advance;

    // Terminal count 2^(PRESCALE_W-speed)-1 is an all-ones mask shifted down.
    assign tc = {PRESCALE_W{1'b1}} >> speed;

    // Highest legal frame index; limit=0 behaves like limit=1.
    assign last_frame = (limit == 5'd0) ? 5'd0 : (limit - 5'd1);

    assign load_req = (asel_s2_q != anim_q);

    always_comb begin
        asel_s1_d  = anim_sel;
        asel_s2_d  = asel_s1_q;
        pause_s1_d = pause;
        pause_s2_d = pause_s1_q;
        step_s1_d  = step_btn;
        step_s2_d  = step_s1_q;
        step_s3_d  = step_s2_q;
        // Registered rising edge: gives the 4th edge its update slot.
        step_evt_d = step_s2_q & ~step_s3_q;

        state_d = state_q;
        anim_d  = anim_q;
        frame_d = frame_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        advance = 1'b0;

        if (load_req) begin
            // A new animation wins over pause, step and any pending advance.
            state_d = ST_LOAD;
            anim_d  = asel_s2_q;
            frame_d = 5'd0;
            pre_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // >= rather than == so a speed increase that leaves the
                    // count above the new TC clears it on the next cycle.
                    if (pre_q >= tc) begin
                        pre_d   = '0;
                        advance = 1'b1;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                    state_d = pause_s2_q ? ST_PAUSED : ST_RUN;
                end
                ST_PAUSED: begin
                    advance = step_evt_q;
                    state_d = pause_s2_q ? ST_PAUSED : ST_RUN;
                end
                ST_LOAD: begin
                    state_d = pause_s2_q ? ST_PAUSED : ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase

            if (advance) begin
                tick_d = 1'b1;
                // Also catches frames left out of range after limit shrinks.
                if (frame_q >= last_frame) begin
                    frame_d = 5'd0;
                    wrap_d  = 1'b1;
                end else begin
                    frame_d = frame_q + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asel_s1_q  <= 3'd0;
            asel_s2_q  <= 3'd0;
            pause_s1_q <= 1'b0;
            pause_s2_q <= 1'b0;
            step_s1_q  <= 1'b0;
            step_s2_q  <= 1'b0;
            step_s3_q  <= 1'b0;
            step_evt_q <= 1'b0;
            state_q    <= ST_RUN;
            anim_q     <= 3'd0;
            frame_q    <= 5'd0;
            pre_q      <= '0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else if (ena) begin
            asel_s1_q  <= asel_s1_d;
            asel_s2_q  <= asel_s2_d;
            pause_s1_q <= pause_s1_d;
            pause_s2_q <= pause_s2_d;
            step_s1_q  <= step_s1_d;
            step_s2_q  <= step_s2_d;
            step_s3_q  <= step_s3_d;
            step_evt_q <= step_evt_d;
            state_q    <= state_d;
            anim_q     <= anim_d;
            frame_q    <= frame_d;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
        end else begin
            // Drop pulses so a pulse is never replayed when ena returns.
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end
    end

    assign anim       = anim_q;
    assign frame      = frame_q;
    assign frame_tick = tick_q & ena;
    assign wrap       = wrap_q & ena;

endmodule

// File: doc/anim_frame_stepper.md
# anim_frame_stepper

Frame sequencer that drives the 7-segment animation pipeline. It synchronises the animation-select inputs and presents the committed animation id to the per-animation frame-limit lookup. It then steps a frame index from 0 to limit−1 at a programmable rate, with wrap-around, pause and single-step. Its frame/animation outputs feed the segment-pattern decoder downstream.

## Interface
Parameters:
- PRESCALE_W, 24, prescaler width; frame period = 2^(PRESCALE_W−speed) clk cycles

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  global enable; low freezes all state (synchronisers included)
- anim_sel  in  3  raw animation select from pins (asynchronous)
- speed  in  2  rate select, 0 = slowest, 3 = fastest
- pause  in  1  raw pause level (asynchronous)
- step_btn  in  1  raw single-step button (asynchronous)
- limit  in  5  frame count for current `anim`, from the limit lookup (combinational from `anim`)
- anim  out  3  committed animation id, to the limit lookup and decoder
- frame  out  5  current frame index
- frame_tick  out  1  one-cycle pulse, high in the first cycle a new `frame` value is visible
- wrap  out  1  one-cycle pulse, high with frame_tick when `frame` returns to 0 by wrap

## Operation
- Reset values: anim=0, frame=0, frame_tick=0, wrap=0, prescaler=0, all sync/edge flops=0, state=RUN.
- anim_sel, pause and step_btn each pass through a 2-flop synchroniser. step_btn has an additional flop for rising-edge detection.
- States: RUN, PAUSED, LOAD.
  - RUN→PAUSED when synced pause=1. PAUSED→RUN when synced pause=0.
  - Any state→LOAD when synced anim_sel ≠ anim. This check has priority over pause and over the step event.
  - LOAD→RUN or PAUSED (per synced pause) after exactly one cycle.
- Entering LOAD registers anim←synced anim_sel. In the LOAD cycle: frame=0, prescaler=0, no frame_tick, no wrap.
- Prescaler (RUN only): counts 0..TC with TC = 2^(PRESCALE_W−speed)−1, then returns to 0 and issues an advance. In PAUSED and LOAD it holds its value.
  - If speed changes so that prescaler > new TC, the prescaler advances and clears on the next cycle.
- Single-step (PAUSED only): a synced step_btn rising edge issues one advance. Edges in RUN are ignored.
- Advance rule, with L = max(limit,1):
  - if frame ≥ L−1, then frame←0 and wrap=1 (this also covers out-of-range frames after limit shrinks, and limit=0);
  - otherwise frame←frame+1.
  - Every advance pulses frame_tick.
- Arithmetic is 5-bit unsigned. limit=31 (lookup default) is legal: frame 0..30.
- ena=0: no state, counter or output changes; pulse outputs are forced 0.

## Timing
- anim_sel change → `anim` update: 3 clk edges (2 sync + commit). frame is 0 from the same edge.
- pause assertion → prescaler frozen: 3 edges. Advances already pending in that window still occur.
- step_btn rising → frame update: 4 edges (2 sync + edge detect + update).
- RUN advance: frame updates on the edge where the prescaler wraps TC→0. frame_tick/wrap are registered and high for exactly that one cycle.
- First advance after LOAD or reset: TC+1 cycles after the prescaler starts counting from 0.
- An anim change in the same cycle as a pending advance: LOAD wins, and the advance is dropped.
- rst_n low at any time (mid-frame, mid-LOAD) immediately returns all outputs to reset values without waiting for a clock. Release proceeds in RUN.

## Test plan
- PRESCALE_W=4, speed=0, anim_sel=0 (limit 10), reset release: frame_tick every 16 cycles; frame runs 0..9 then 0 with wrap=1 on the 10th tick.
- speed=3, anim_sel=7 (limit 2): ticks every 2 cycles; frame alternates 0,1,0 with wrap on every second tick.
- Hold frame=9 on anim 0, change anim_sel to 2 (limit 6): anim=2 after 3 edges, frame=0, no tick in the LOAD cycle, next tick after 16 cycles gives frame=1.
- pause=1: frame constant for ≥100 cycles. Three step_btn pulses yield frame +3 (each 4 edges after its rising edge). Steps held high produce only one advance each.
- Force limit=0 via a stub lookup: frame stays 0 and every tick has wrap=1. Shrink limit from 12 to 6 while frame=10: next advance gives frame=0 with wrap.
- Assert rst_n low mid-count with ena toggling: outputs are 0 asynchronously. With ena=0, frame and prescaler hold and frame_tick=0.
